addsub_result_display: RTL and testbench

ADDSUB_RESULT_DISPLAY -- requirements
Module: addsub_result_display

---
 rtl/addsub_result_display_pkg.sv | 39 +++
 rtl/addsub_result_display_seg7_decode.sv | 25 ++
 rtl/addsub_result_display.sv | 150 +++++++++++++++
 tb/tb_addsub_result_display.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_result_display_pkg.sv
// Shared types and constants for the adder/subtractor result display:
// controller states, 7-segment codes and the BCD correction helper.
package addsub_result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_t;

    // Segment codes, bit order gfedcba, active-high
    localparam logic [6:0] SEG_D0    = 7'h3F;
    localparam logic [6:0] SEG_D1    = 7'h06;
    localparam logic [6:0] SEG_D2    = 7'h5B;
    localparam logic [6:0] SEG_D3    = 7'h4F;
    localparam logic [6:0] SEG_D4    = 7'h66;
    localparam logic [6:0] SEG_D5    = 7'h6D;
    localparam logic [6:0] SEG_D6    = 7'h7D;
    localparam logic [6:0] SEG_D7    = 7'h07;
    localparam logic [6:0] SEG_D8    = 7'h7F;
    localparam logic [6:0] SEG_D9    = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // One shift per input bit of the 5-bit value
    localparam int CONV_CYCLES = 5;

    typedef struct packed {
        logic       sign;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       ovf;
    } disp_t;

    function automatic logic [3:0] bcd_add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/addsub_result_display_seg7_decode.sv
// Combinational BCD digit to 7-segment decoder (gfedcba, active-high).
module seg7_decode
    import addsub_result_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/addsub_result_display.sv
// Captures a 4-bit add/sub result, converts it to BCD by double-dabble and
// scans sign/tens/ones onto a multiplexed 7-segment display.
module addsub_result_display
    import addsub_result_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] mag,
    input  logic       cout_in,
    input  logic       neg,
    input  logic       ctrl,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       ovf
);

    localparam logic [15:0] DIV_LAST  = 16'(REFRESH_DIV - 1);
    localparam logic [2:0]  CONV_LAST = 3'(CONV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  bin_q, bin_d;
    logic [3:0]  bcd_tens_q, bcd_tens_d;
    logic [3:0]  bcd_ones_q, bcd_ones_d;
    logic        pend_sign_q, pend_sign_d;
    logic        pend_ovf_q, pend_ovf_d;
    disp_t       disp_q, disp_d;
    logic        shown_q, shown_d;
    logic [15:0] pre_q, pre_d;
    logic [1:0]  dig_q, dig_d;

    logic        xfer;
    logic [12:0] dd_vec;
    logic [12:0] dd_shift;
    logic [3:0]  dec_digit;
    logic [6:0]  dec_seg;

    assign in_ready = (state_q != ST_CONVERT);
    assign xfer     = in_valid && in_ready;

    // Add-3 correction then shift one binary bit into the BCD pair
    assign dd_vec   = {bcd_add3(bcd_tens_q), bcd_add3(bcd_ones_q), bin_q};
    assign dd_shift = dd_vec << 1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_tens_d  = bcd_tens_q;
        bcd_ones_d  = bcd_ones_q;
        pend_sign_d = pend_sign_q;
        pend_ovf_d  = pend_ovf_q;
        disp_d      = disp_q;
        shown_d     = shown_q;
        case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (xfer) begin
                    state_d     = ST_CONVERT;
                    cnt_d       = 3'd0;
                    bin_d       = ctrl ? {1'b0, mag} : {cout_in, mag};
                    bcd_tens_d  = 4'd0;
                    bcd_ones_d  = 4'd0;
                    pend_sign_d = ctrl & neg;
                    pend_ovf_d  = ~ctrl & cout_in;
                end
            end
            ST_CONVERT: begin
                bcd_tens_d = dd_shift[12:9];
                bcd_ones_d = dd_shift[8:5];
                bin_d      = dd_shift[4:0];
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == CONV_LAST) begin
                    state_d = ST_SHOW;
                    disp_d  = '{sign: pend_sign_q, tens: dd_shift[12:9],
                                ones: dd_shift[8:5], ovf: pend_ovf_q};
                    shown_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pre_d = pre_q + 16'd1;
        dig_d = dig_q;
        if (pre_q == DIV_LAST) begin
            pre_d = 16'd0;
            dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            bin_q       <= 5'd0;
            bcd_tens_q  <= 4'd0;
            bcd_ones_q  <= 4'd0;
            pend_sign_q <= 1'b0;
            pend_ovf_q  <= 1'b0;
            disp_q      <= '0;
            shown_q     <= 1'b0;
            pre_q       <= 16'd0;
            dig_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_tens_q  <= bcd_tens_d;
            bcd_ones_q  <= bcd_ones_d;
            pend_sign_q <= pend_sign_d;
            pend_ovf_q  <= pend_ovf_d;
            disp_q      <= disp_d;
            shown_q     <= shown_d;
            pre_q       <= pre_d;
            dig_q       <= dig_d;
        end
    end

    assign dec_digit = (dig_q == 2'd1) ? disp_q.tens : disp_q.ones;

    seg7_decode u_dec (
        .digit (dec_digit),
        .seg   (dec_seg)
    );

    always_comb begin
        case (dig_q)
            2'd1:    an = 3'b010;
            2'd2:    an = 3'b100;
            default: an = 3'b001;
        endcase
        seg = SEG_BLANK;
        if (shown_q) begin
            case (dig_q)
                2'd0:    seg = dec_seg;
                2'd1:    seg = (disp_q.tens == 4'd0) ? SEG_BLANK : dec_seg;
                2'd2:    seg = disp_q.sign ? SEG_MINUS : SEG_BLANK;
                default: seg = SEG_BLANK;
            endcase
        end
    end

    assign ovf = disp_q.ovf;

endmodule

// File: tb/tb_addsub_result_display.sv
// Scoreboard bench: expected digits queued on each transfer, compared when
// the display updates; a second instance checks the slower scan rate.
module tb_addsub_result_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] mag = 4'd0;
    logic       cout_in = 1'b0;
    logic       neg = 1'b0;
    logic       ctrl = 1'b0;

    logic       in_ready, ovf;
    logic [6:0] seg;
    logic [2:0] an;
    logic       in_ready_s, ovf_s;
    logic [6:0] seg_s;
    logic [2:0] an_s;

    int total = 0;
    int bad = 0;
    logic prev_ovf = 1'b0;

    typedef struct {
        logic [6:0] sgn;
        logic [6:0] tns;
        logic [6:0] one;
        logic       ov;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    addsub_result_display #(.REFRESH_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mag(mag), .cout_in(cout_in), .neg(neg), .ctrl(ctrl),
        .seg(seg), .an(an), .ovf(ovf)
    );

    addsub_result_display #(.REFRESH_DIV(3)) dut_slow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .mag(mag), .cout_in(cout_in), .neg(neg), .ctrl(ctrl),
        .seg(seg_s), .an(an_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [2:0] an_of(input int i);
        logic [2:0] one = 3'b001;
        return one << i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_digits(input string tag);
        exp_t e;
        logic [6:0] got[3];
        int idx;
        for (int k = 0; k < 3; k++) got[k] = 'x;
        e = sb.pop_front();
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_an_onehot"}, $countones(an), 1);
            idx = (an == 3'b001) ? 0 : (an == 3'b010) ? 1 : (an == 3'b100) ? 2 : -1;
            if (idx >= 0) got[idx] = seg;
            step();
        end
        chk({tag, "_sign"}, 32'(got[2]), 32'(e.sgn));
        chk({tag, "_tens"}, 32'(got[1]), 32'(e.tns));
        chk({tag, "_ones"}, 32'(got[0]), 32'(e.one));
        $display("txn %s: sign=%02h tens=%02h ones=%02h ovf=%0b", tag, got[2], got[1], got[0], ovf);
        prev_ovf = e.ov;
    endtask

    task automatic send(input string tag, input logic [3:0] m, input logic c,
                        input logic n, input logic op, input bit hold);
        exp_t e;
        int v;
        int cnt;
        mag = m; cout_in = c; neg = n; ctrl = op; in_valid = 1'b1;
        chk({tag, "_ready_pre"}, 32'(in_ready), 1);
        v = op ? int'(m) : int'({c, m});
        e.sgn = (op && n) ? 7'h40 : 7'h00;
        e.tns = (v / 10 == 0) ? 7'h00 : seg_of(v / 10);
        e.one = seg_of(v % 10);
        e.ov  = !op && c;
        sb.push_back(e);
        step();
        if (!hold) in_valid = 1'b0;
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 20) begin
            chk({tag, "_ovf_hold"}, 32'(ovf), 32'(prev_ovf));
            if (hold) mag = 4'($urandom_range(0, 15));
            step();
            cnt++;
        end
        in_valid = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(cnt), 5);
        read_digits(tag);
    endtask

    task automatic check_blank(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            chk({tag, "_seg"}, 32'(seg), 0);
            chk({tag, "_ready"}, 32'(in_ready), 1);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_seg", 32'(seg), 0);
        chk("rst_an", 32'(an), 32'(3'b001));
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_seg_slow", 32'(seg_s), 0);
        chk("rst_ready_slow", 32'(in_ready_s), 1);
        chk("rst_ovf_slow", 32'(ovf_s), 0);
        for (int k = 0; k < 12; k++) begin
            chk("scan_div1", 32'(an), 32'(an_of(k % 3)));
            chk("scan_div3", 32'(an_s), 32'(an_of((k / 3) % 3)));
            chk("idle_seg", 32'(seg), 0);
            step();
        end
        $display("txn scan: rates 1 and 3 checked");

        send("add_9p9", 4'd2, 1'b1, 1'b0, 1'b0, 0);
        send("sub_3m7", 4'd4, 1'b0, 1'b1, 1'b1, 0);
        send("add_0p0", 4'd0, 1'b0, 1'b0, 1'b0, 0);
        send("add_15p15", 4'd14, 1'b1, 1'b0, 1'b0, 0);
        send("add_31_negign", 4'd15, 1'b1, 1'b1, 1'b0, 0);
        send("sub_pos15", 4'd15, 1'b0, 1'b0, 1'b1, 0);
        send("add_hold", 4'd7, 1'b0, 1'b0, 1'b0, 1);
        for (int r = 0; r < 4; r++)
            send("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        mag = 4'd9; cout_in = 1'b1; neg = 1'b0; ctrl = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_ready", 32'(in_ready), 1);
        chk("midrst_an", 32'(an), 32'(3'b001));
        chk("midrst_ovf", 32'(ovf), 0);
        check_blank("midrst", 8);
        $display("txn midrst: conversion aborted");
        prev_ovf = 1'b0;

        send("after_rst", 4'd3, 1'b0, 1'b1, 1'b1, 0);
        mag = 4'd9; cout_in = 1'b1; ctrl = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("rstxfer_ovf", 32'(ovf), 0);
        check_blank("rstxfer", 8);
        $display("txn rstxfer: offered result dropped");
        prev_ovf = 1'b0;
        send("final", 4'd5, 1'b1, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
